// File: rtl/game_score_keeper.sv
// Score keeper for N players: BCD goal counting, win detection,
// serve-delay sequencing and winner flash. All outputs come straight from flops.
module game_score_keeper #(
  parameter int unsigned N_PLAYERS    = 2,
  parameter int unsigned DIGITS       = 2,
  parameter int unsigned WIN_SCORE    = 11,
  parameter int unsigned SERVE_DELAY  = 60,
  parameter int unsigned FLASH_PERIOD = 30,
  parameter int unsigned CNT_W        = 16,
  localparam int unsigned WIN_W       = (N_PLAYERS > 1) ? $clog2(N_PLAYERS) : 1
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic [N_PLAYERS-1:0]          goal_i,
  input  logic                          new_game_i,
  output logic [N_PLAYERS*DIGITS*4-1:0] score_bcd_o,
  output logic                          freeze_o,
  output logic                          serve_o,
  output logic                          game_over_o,
  output logic [WIN_W-1:0]              winner_o,
  output logic                          flash_o
);

  localparam int unsigned SW = DIGITS * 4;
  localparam int unsigned TW = N_PLAYERS * SW;

  typedef enum logic [1:0] {StPlay, StServeWait, StOver} state_e;

  // Binary to packed BCD, used only to build the win constant.
  function automatic logic [SW-1:0] to_bcd(input int unsigned value);
    logic [SW-1:0] bcd;
    int unsigned   rem;
    bcd = '0;
    rem = value;
    for (int d = 0; d < int'(DIGITS); d++) begin
      bcd[d*4 +: 4] = 4'(rem % 10);
      rem           = rem / 10;
    end
    return bcd;
  endfunction

  // Multi-digit BCD increment; a 9 rolls to 0 and carries upward.
  function automatic logic [SW-1:0] bcd_inc(input logic [SW-1:0] value);
    logic [SW-1:0] res;
    logic          carry;
    res   = value;
    carry = 1'b1;
    for (int d = 0; d < int'(DIGITS); d++) begin
      if (carry) begin
        if (value[d*4 +: 4] == 4'd9) begin
          res[d*4 +: 4] = 4'd0;
        end else begin
          res[d*4 +: 4] = value[d*4 +: 4] + 4'd1;
          carry         = 1'b0;
        end
      end
    end
    return res;
  endfunction

  localparam logic [SW-1:0]    WIN_BCD    = to_bcd(WIN_SCORE);
  localparam logic [CNT_W-1:0] SERVE_LOAD = CNT_W'(SERVE_DELAY - 1);
  localparam logic [CNT_W-1:0] FLASH_LAST = CNT_W'(FLASH_PERIOD - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [TW-1:0]    score_q, score_d;
  logic [WIN_W-1:0] winner_q, winner_d;
  logic             flash_q, flash_d;
  logic             freeze_q, freeze_d;
  logic             serve_q, serve_d;
  logic             over_q, over_d;

  int               scorer_idx;
  logic [SW-1:0]    inc_val;

  // State register and all registered outputs.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= StServeWait;
      cnt_q    <= SERVE_LOAD;
      score_q  <= '0;
      winner_q <= '0;
      flash_q  <= 1'b0;
      freeze_q <= 1'b1;
      serve_q  <= 1'b0;
      over_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      score_q  <= score_d;
      winner_q <= winner_d;
      flash_q  <= flash_d;
      freeze_q <= freeze_d;
      serve_q  <= serve_d;
      over_q   <= over_d;
    end
  end

  // Next-state logic: scoring, serve countdown, flash timing.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    score_d    = score_q;
    winner_d   = winner_q;
    flash_d    = flash_q;
    scorer_idx = 0;
    // Descending scan so the lowest set index wins.
    for (int k = int'(N_PLAYERS) - 1; k >= 0; k--) begin
      if (goal_i[k]) scorer_idx = k;
    end
    inc_val = bcd_inc(score_q[scorer_idx*SW +: SW]);

    if (new_game_i) begin
      score_d  = '0;
      winner_d = '0;
      flash_d  = 1'b0;
      state_d  = StServeWait;
      cnt_d    = SERVE_LOAD;
    end else begin
      unique case (state_q)
        StPlay: begin
          if (|goal_i) begin
            score_d[scorer_idx*SW +: SW] = inc_val;
            if (inc_val == WIN_BCD) begin
              state_d  = StOver;
              winner_d = WIN_W'(scorer_idx);
              cnt_d    = '0;
              flash_d  = 1'b1;
            end else begin
              state_d = StServeWait;
              cnt_d   = SERVE_LOAD;
            end
          end
        end
        StServeWait: begin
          if (cnt_q == '0) begin
            state_d = StPlay;
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
        StOver: begin
          if (cnt_q == FLASH_LAST) begin
            cnt_d   = '0;
            flash_d = ~flash_q;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        default: begin
          state_d = StServeWait;
          cnt_d   = SERVE_LOAD;
        end
      endcase
    end
  end

  // Output decode from the next state so the flops present it one cycle later.
  always_comb begin
    freeze_d = (state_d != StPlay);
    over_d   = (state_d == StOver);
    serve_d  = (state_d == StServeWait) && (cnt_d == '0);
  end

  assign score_bcd_o = score_q;
  assign freeze_o    = freeze_q;
  assign serve_o     = serve_q;
  assign game_over_o = over_q;
  assign winner_o    = winner_q;
  assign flash_o     = flash_q;

endmodule

// File: tb/tb_game_score_keeper.sv
// Directed bench for game_score_keeper: a 2-player/2-digit instance with a
// table of per-cycle vectors plus multi-cycle sequences, and a 4-player/3-digit
// instance with a one-cycle serve delay.
module tb_game_score_keeper;

  localparam int unsigned SD_A = 4;
  localparam int unsigned FP_A = 5;

  logic clk;
  logic rst_a, rst_b;
  logic [1:0] goal_a;
  logic       ng_a;
  logic [15:0] score_a;
  logic freeze_a, serve_a, over_a, flash_a;
  logic [0:0] winner_a;

  logic [3:0]  goal_b;
  logic        ng_b;
  logic [47:0] score_b;
  logic freeze_b, serve_b, over_b, flash_b;
  logic [1:0] winner_b;

  int n_checks = 0;
  int n_err    = 0;

  game_score_keeper #(
    .N_PLAYERS(2), .DIGITS(2), .WIN_SCORE(11), .SERVE_DELAY(SD_A),
    .FLASH_PERIOD(FP_A), .CNT_W(8)
  ) u_dut_a (
    .clk_i(clk), .rst_ni(rst_a), .goal_i(goal_a), .new_game_i(ng_a),
    .score_bcd_o(score_a), .freeze_o(freeze_a), .serve_o(serve_a),
    .game_over_o(over_a), .winner_o(winner_a), .flash_o(flash_a)
  );

  game_score_keeper #(
    .N_PLAYERS(4), .DIGITS(3), .WIN_SCORE(200), .SERVE_DELAY(1),
    .FLASH_PERIOD(3), .CNT_W(4)
  ) u_dut_b (
    .clk_i(clk), .rst_ni(rst_b), .goal_i(goal_b), .new_game_i(ng_b),
    .score_bcd_o(score_b), .freeze_o(freeze_b), .serve_o(serve_b),
    .game_over_o(over_b), .winner_o(winner_b), .flash_o(flash_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  goal;
    logic        ng;
    logic [15:0] score;
    logic        fr, sv, ov, w, fl;
  } vec_t;

  vec_t vecs [15];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] mk_a(input logic [15:0] sc, input logic fr, input logic sv,
                                       input logic ov, input logic w, input logic fl);
    return {43'b0, sc, fr, sv, ov, w, fl};
  endfunction

  function automatic logic [63:0] got_a();
    return {43'b0, score_a, freeze_a, serve_a, over_a, winner_a, flash_a};
  endfunction

  task automatic step_a(input logic [1:0] g, input logic ng);
    goal_a = g;
    ng_a   = ng;
    @(posedge clk);
    #1;
    goal_a = '0;
    ng_a   = 1'b0;
  endtask

  task automatic step_b(input logic [3:0] g);
    goal_b = g;
    @(posedge clk);
    #1;
    goal_b = '0;
  endtask

  // Called while in SERVE_WAIT with the counter freshly loaded.
  task automatic serve_seq_a(input string name);
    for (int k = 1; k <= int'(SD_A); k++) begin
      step_a(2'b00, 1'b0);
      check(name, {62'b0, freeze_a, serve_a}, {62'b0, k != int'(SD_A), k == int'(SD_A) - 1});
    end
  endtask

  task automatic goal_serve_a(input logic [1:0] g);
    step_a(g, 1'b0);
    serve_seq_a("goal_serve");
  endtask

  initial begin
    rst_a  = 1'b0;
    rst_b  = 1'b0;
    goal_a = '0;
    ng_a   = 1'b0;
    goal_b = '0;
    ng_b   = 1'b0;

    //                goal   ng    score     fr    sv    ov    w     fl
    vecs[0]  = '{2'b00, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[1]  = '{2'b00, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[2]  = '{2'b00, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[3]  = '{2'b00, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[4]  = '{2'b11, 1'b0, 16'h0001, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[5]  = '{2'b10, 1'b0, 16'h0001, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[6]  = '{2'b01, 1'b0, 16'h0001, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[7]  = '{2'b00, 1'b0, 16'h0001, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[8]  = '{2'b10, 1'b0, 16'h0001, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[9]  = '{2'b00, 1'b0, 16'h0001, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[10] = '{2'b01, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[11] = '{2'b00, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[12] = '{2'b00, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[13] = '{2'b00, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[14] = '{2'b00, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};

    repeat (2) @(posedge clk);
    #1;
    check("reset_a", got_a(), mk_a(16'h0000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0));
    check("reset_b", {9'b0, score_b, freeze_b, serve_b, over_b, winner_b, flash_b},
          {9'b0, 48'h0, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0});
    @(negedge clk);
    rst_a = 1'b1;

    foreach (vecs[i]) begin
      step_a(vecs[i].goal, vecs[i].ng);
      check($sformatf("vec%0d", i), got_a(),
            mk_a(vecs[i].score, vecs[i].fr, vecs[i].sv, vecs[i].ov, vecs[i].w, vecs[i].fl));
    end

    // Player1 nine goals, then the tens carry.
    repeat (9) goal_serve_a(2'b10);
    check("p1_nine", {48'b0, score_a}, 64'h0900);
    goal_serve_a(2'b10);
    check("p1_carry", {48'b0, score_a}, 64'h1000);

    // Player0 wins at 11.
    repeat (10) goal_serve_a(2'b01);
    check("p0_ten", {48'b0, score_a}, 64'h1010);
    step_a(2'b01, 1'b0);
    check("win_p0", got_a(), mk_a(16'h1011, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1));
    for (int i = 1; i <= 15; i++) begin
      step_a(2'b11, 1'b0);
      check($sformatf("flash%0d", i), got_a(),
            mk_a(16'h1011, 1'b1, 1'b0, 1'b1, 1'b0, ((i / int'(FP_A)) % 2) == 0));
    end

    // New game out of OVER.
    step_a(2'b00, 1'b1);
    check("ng_over", got_a(), mk_a(16'h0000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0));
    serve_seq_a("ng_over_serve");

    // Second game: player1 wins, winner index latched then cleared.
    repeat (10) goal_serve_a(2'b10);
    step_a(2'b10, 1'b0);
    check("win_p1", got_a(), mk_a(16'h1100, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1));
    step_a(2'b00, 1'b1);
    check("ng_over2", got_a(), mk_a(16'h0000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0));
    serve_seq_a("ng_over2_serve");

    // Async reset in the middle of SERVE_WAIT, between clock edges.
    step_a(2'b01, 1'b0);
    check("pre_rst", got_a(), mk_a(16'h0001, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0));
    step_a(2'b00, 1'b0);
    #2;
    rst_a = 1'b0;
    #1;
    check("async_rst", got_a(), mk_a(16'h0000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0));
    repeat (2) @(negedge clk);
    rst_a = 1'b1;
    serve_seq_a("post_rst_serve");
    check("post_rst_play", got_a(), mk_a(16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));

    // Wide build: one-cycle serve delay, three-digit packing.
    @(negedge clk);
    rst_b = 1'b1;
    step_b(4'b0000);
    check("b_play", {63'b0, freeze_b}, 64'd0);
    for (int i = 1; i <= 105; i++) begin
      step_b(4'b1000);
      check("b_goal_serve", {62'b0, freeze_b, serve_b}, 64'd3);
      step_b(4'b0000);
      check("b_resume", {62'b0, freeze_b, serve_b}, 64'd0);
      if (i == 99) check("b_99", {16'b0, score_b}, 64'h099_000_000_000);
      if (i == 100) check("b_100", {16'b0, score_b}, 64'h100_000_000_000);
    end
    check("b_105", {16'b0, score_b}, 64'h105_000_000_000);
    step_b(4'b0110);
    check("b_lowest", {16'b0, score_b}, 64'h105_000_001_000);
    check("b_not_over", {60'b0, over_b, winner_b, flash_b}, 64'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
